// File: rtl/rom_scan_ctrl.sv
// rtl/rom_scan_ctrl.sv - ROM scan controller: reads addresses 0..LAST_ADDR and sums accepted words.
// Optional build macro: SCAN_ODD_FILTER_EN (when defined, only words with bit 0 set are accepted).

module rom_scan_ctrl #(
   parameter logic [3:0] LAST_ADDR = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  rom_addr,
   output logic        rom_rd_en,
   input  logic [31:0] rom_data,
   output logic        busy,
   output logic        done,
   output logic [35:0] sum,
   output logic [4:0]  match_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  counter;
   logic [31:0] data_q;
   logic        valid_q;
   logic        word_accept;
   logic        scan_start;

   // A start request is only honoured from IDLE; elsewhere it is dropped.
   assign scan_start = (state == IDLE) && start;

`ifdef SCAN_ODD_FILTER_EN
   assign word_accept = data_q[0];
`else
   assign word_accept = 1'b1;
`endif

   // State register; reset wins over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and Moore outputs; the ROM address is only driven from the counter while scanning.
   always_comb begin
      state_nxt = state;
      rom_rd_en = 1'b0;
      rom_addr  = 4'd0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            rom_rd_en = 1'b1;
            rom_addr  = counter;
            busy      = 1'b1;
            if (counter == LAST_ADDR) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Address counter: cleared on an accepted start, advances during SCAN and saturates at LAST_ADDR.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter <= 4'd0;
      end else if (scan_start) begin
         counter <= 4'd0;
      end else if ((state == SCAN) && (counter != LAST_ADDR)) begin
         counter <= counter + 4'd1;
      end
   end

   // Capture stage: every SCAN cycle registers the ROM word; any other state empties the stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= 32'd0;
         valid_q <= 1'b0;
      end else if (state == SCAN) begin
         data_q  <= rom_data;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   // Accumulate stage: one cycle behind capture, so the last word lands during DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= 36'd0;
         match_cnt <= 5'd0;
      end else if (scan_start) begin
         sum       <= 36'd0;
         match_cnt <= 5'd0;
      end else if (valid_q && word_accept) begin
         sum       <= sum + {4'd0, data_q};
         match_cnt <= match_cnt + 5'd1;
      end
   end

endmodule

// File: doc/rom_scan_ctrl.md
ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

Interface
REQ-001 Parameter LAST_ADDR, default 4'hF, final ROM address scanned; the scan always starts at address 0.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 rom_addr  output  4  address to the 16x32 ROM addr port.
REQ-006 rom_rd_en  output  1  drives the ROM rd_en port.
REQ-007 rom_data  input  32  ROM data port; combinational, valid in the same cycle as rom_addr.
REQ-008 busy  output  1  high in SCAN and DRAIN.
REQ-009 done  output  1  single-cycle pulse, high only in DONE.
REQ-010 sum  output  36  unsigned sum of accepted words.
REQ-011 match_cnt  output  5  number of accepted words.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SCAN, DRAIN, DONE.
REQ-013 IDLE: rom_rd_en=0, rom_addr=0; start=1 SHALL clear sum, match_cnt and the address counter, then go to SCAN.
REQ-014 SCAN: rom_rd_en=1, rom_addr=counter; each cycle rom_data SHALL be registered into data_q with valid_q=1, and the counter SHALL increment.
REQ-015 SCAN SHALL go to DRAIN in the cycle after the one where counter==LAST_ADDR; the counter SHALL never wrap past LAST_ADDR.
REQ-016 Accumulation SHALL occur one cycle after capture: when valid_q=1 and the word is accepted, sum += zero-extended data_q and match_cnt += 1.
REQ-017 DRAIN: rom_rd_en=0; the last captured word SHALL be accumulated; valid_q cleared; next state DONE.
REQ-018 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-019 Latency: with start high in cycle T (IDLE) and LAST_ADDR=15:
- SCAN in T+1..T+16
- DRAIN in T+17
- done=1 in T+18
- sum/match_cnt final from T+18
REQ-020 sum and match_cnt SHALL hold their final values after DONE until the next accepted start.
REQ-021 start in SCAN, DRAIN or DONE SHALL be ignored, with no queuing.
REQ-022 With start held high, a new scan SHALL begin from each IDLE cycle, giving a period of LAST_ADDR+4 cycles.
REQ-023 sum width SHALL be 36 bits so that 16 words of 32'hFFFF_FFFF cannot overflow.

Reset
REQ-024 rst=1 SHALL force the following on the next rising edge, from any state including mid-scan, with priority over start:
- state=IDLE
- rom_addr=0, rom_rd_en=0
- busy=0, done=0
- sum=0, match_cnt=0
- counter=0, data_q=0, valid_q=0

Configuration
REQ-025 When the macro SCAN_ODD_FILTER_EN is defined, a word SHALL be accepted only if bit 0 = 1.
REQ-026 When SCAN_ODD_FILTER_EN is undefined, every scanned word SHALL be accepted, and match_cnt SHALL equal LAST_ADDR+1 at DONE.

Verification
REQ-027 ROM[i]=i+1, filter off, start pulse at T -> done at T+18, sum=36'h88, match_cnt=16.
REQ-028 ROM[i]=i+1, SCAN_ODD_FILTER_EN defined -> sum=36'h40, match_cnt=8.
REQ-029 ROM all 32'hFFFF_FFFF, filter off -> sum=36'hF_FFFF_FFF0, match_cnt=16.
REQ-030 rst asserted during the 5th SCAN cycle -> next cycle: IDLE, rom_rd_en=0, busy=0, sum=0, match_cnt=0; a later start gives a full, correct scan.
REQ-031 start held high for 40 cycles -> done pulses at T+18 and T+37; start during busy is not queued; sum=36'h88 both times.
REQ-032 LAST_ADDR=3, ROM[i]=i+1, filter off -> rom_addr sequence 0,1,2,3; done at T+6; sum=36'hA; match_cnt=4.
